// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI slave protocol engine.
package spi_slave_pkg;

   localparam int DEF_ADDR_WIDTH = 7;
   localparam int DEF_DATA_WIDTH = 8;
   localparam logic RW_READ = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_GET_ADDR   = 4'd1,
      ST_LATCH_ADDR = 4'd2,
      ST_READ_WAIT  = 4'd3,
      ST_READ_LOAD  = 4'd4,
      ST_READ_SHIFT = 4'd5,
      ST_GET_DATA   = 4'd6,
      ST_WRITE      = 4'd7,
      ST_DONE       = 4'd8
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_shiftreg.sv
// Frame shift register: parallel load, serial-in at LSB, MSB-first serial-out register.
module spi_shiftreg #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load_en,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_shift_in_en,
   input  logic             i_shift_in_bit,
   input  logic             i_shift_out_en,
   output logic [WIDTH-1:0] o_data,
   output logic             o_serial_out
);

   logic [WIDTH-1:0] r_sr;
   logic             r_serial;

   // Shift/load register with the serial output bit held in its own flop
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sr     <= {WIDTH{1'b0}};
         r_serial <= 1'b0;
      end else if (i_load_en) begin
         r_sr <= i_load_data;
      end else if (i_shift_in_en) begin
         r_sr <= {r_sr[WIDTH-2:0], i_shift_in_bit};
      end else if (i_shift_out_en) begin
         r_serial <= r_sr[WIDTH-1];
         r_sr     <= {r_sr[WIDTH-2:0], 1'b0};
      end else begin
         r_sr     <= r_sr;
         r_serial <= r_serial;
      end
   end

   assign o_data       = r_sr;
   assign o_serial_out = r_serial;

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave protocol engine: address + R/W frame, then memory write or serial read-back.
// Optional aborted-frame detection on proto_err is enabled by SPI_SLAVE_PROTO_CHECK_EN.
module spi_slave_fsm
   import spi_slave_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs_cond,
   input  logic                  mosi_cond,
   input  logic                  sclk_posedge,
   input  logic                  sclk_negedge,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  miso,
   output logic                  miso_en,
   output logic                  proto_err
);

   localparam int SR_W = max_int(ADDR_WIDTH + 1, DATA_WIDTH);

   state_t                r_state;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_we;
   logic                  r_miso_en;

   logic                  w_abort;
   logic                  w_load_en;
   logic                  w_shift_in_en;
   logic                  w_shift_out_en;
   logic [SR_W-1:0]       w_load_data;
   logic [SR_W-1:0]       w_sr;
   logic                  w_miso;

   // A CS release outranks any edge pulse arriving in the same clock
   assign w_abort        = (r_state != ST_IDLE) && cs_cond;
   assign w_load_en      = !w_abort && (r_state == ST_READ_LOAD);
   assign w_shift_in_en  = !w_abort && sclk_posedge &&
                           ((r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA));
   assign w_shift_out_en = !w_abort && sclk_negedge && (r_state == ST_READ_SHIFT);
   assign w_load_data    = SR_W'(mem_rdata) << (SR_W - DATA_WIDTH);

   spi_shiftreg #(.WIDTH(SR_W)) u_sr (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_load_en      (w_load_en),
      .i_load_data    (w_load_data),
      .i_shift_in_en  (w_shift_in_en),
      .i_shift_in_bit (mosi_cond),
      .i_shift_out_en (w_shift_out_en),
      .o_data         (w_sr),
      .o_serial_out   (w_miso)
   );

`ifdef SPI_SLAVE_PROTO_CHECK_EN
   logic r_proto_err;
`endif

   // Protocol state machine with registered memory and MISO-enable outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= {CNT_WIDTH{1'b0}};
         r_addr    <= {ADDR_WIDTH{1'b0}};
         r_wdata   <= {DATA_WIDTH{1'b0}};
         r_we      <= 1'b0;
         r_miso_en <= 1'b0;
`ifdef SPI_SLAVE_PROTO_CHECK_EN
         r_proto_err <= 1'b0;
`endif
      end else begin
         r_we <= 1'b0;
`ifdef SPI_SLAVE_PROTO_CHECK_EN
         r_proto_err <= 1'b0;
`endif
         if (w_abort) begin
            r_state   <= ST_IDLE;
            r_cnt     <= {CNT_WIDTH{1'b0}};
            r_miso_en <= 1'b0;
`ifdef SPI_SLAVE_PROTO_CHECK_EN
            r_proto_err <= (r_state != ST_DONE);
`endif
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (!cs_cond) begin
                     r_state <= ST_GET_ADDR;
                     r_cnt   <= {CNT_WIDTH{1'b0}};
                  end
               end
               ST_GET_ADDR: begin
                  if (sclk_posedge) begin
                     r_cnt <= r_cnt + CNT_WIDTH'(1);
                     if (r_cnt == CNT_WIDTH'(ADDR_WIDTH)) begin
                        r_state <= ST_LATCH_ADDR;
                     end
                  end
               end
               ST_LATCH_ADDR: begin
                  r_addr  <= w_sr[ADDR_WIDTH:1];
                  r_cnt   <= {CNT_WIDTH{1'b0}};
                  r_state <= (w_sr[0] == RW_READ) ? ST_READ_WAIT : ST_GET_DATA;
               end
               ST_READ_WAIT: begin
                  r_state <= ST_READ_LOAD;
               end
               ST_READ_LOAD: begin
                  r_miso_en <= 1'b1;
                  r_state   <= ST_READ_SHIFT;
               end
               ST_READ_SHIFT: begin
                  if (sclk_posedge) begin
                     r_cnt <= r_cnt + CNT_WIDTH'(1);
                     if (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        r_state   <= ST_DONE;
                        r_miso_en <= 1'b0;
                     end
                  end
               end
               ST_GET_DATA: begin
                  if (sclk_posedge) begin
                     r_cnt <= r_cnt + CNT_WIDTH'(1);
                     if (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        r_state <= ST_WRITE;
                     end
                  end
               end
               // Strobe is raised only once the WRITE cycle survives without a CS release
               ST_WRITE: begin
                  r_we    <= 1'b1;
                  r_wdata <= w_sr[DATA_WIDTH-1:0];
                  r_state <= ST_DONE;
               end
               ST_DONE: begin
                  r_state <= ST_DONE;
               end
               default: begin
                  r_state   <= ST_IDLE;
                  r_cnt     <= {CNT_WIDTH{1'b0}};
                  r_miso_en <= 1'b0;
               end
            endcase
         end
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_we    = r_we;
   assign miso      = w_miso;
   assign miso_en   = r_miso_en;
`ifdef SPI_SLAVE_PROTO_CHECK_EN
   assign proto_err = r_proto_err;
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed self-checking bench for spi_slave_fsm (write, read, abort, race, reset, idle noise).
module tb_spi_slave_fsm;
   import spi_slave_pkg::*;

   logic       clk;
   logic       reset;
   logic       cs_cond;
   logic       mosi_cond;
   logic       sclk_posedge;
   logic       sclk_negedge;
   logic [7:0] mem_rdata;
   logic [6:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic       miso;
   logic       miso_en;
   logic       proto_err;

   logic [7:0] mem [0:127];

   int errors = 0;
   int checks = 0;
   int we_cnt = 0;
   int pe_cnt = 0;
   logic [6:0] we_addr = 7'd0;
   logic [7:0] we_data = 8'd0;

`ifdef SPI_SLAVE_PROTO_CHECK_EN
   localparam int PE_PER_ABORT = 1;
`else
   localparam int PE_PER_ABORT = 0;
`endif

   spi_slave_fsm dut (
      .clk          (clk),
      .reset        (reset),
      .cs_cond      (cs_cond),
      .mosi_cond    (mosi_cond),
      .sclk_posedge (sclk_posedge),
      .sclk_negedge (sclk_negedge),
      .mem_rdata    (mem_rdata),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .miso         (miso),
      .miso_en      (miso_en),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) begin
         we_cnt  = we_cnt + 1;
         we_addr = mem_addr;
         we_data = mem_wdata;
      end
      if (proto_err) pe_cnt = pe_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pos(input logic b);
      mosi_cond    = b;
      sclk_posedge = 1'b1;
      step();
      sclk_posedge = 1'b0;
      repeat (4) step();
   endtask

   task automatic neg();
      sclk_negedge = 1'b1;
      step();
      sclk_negedge = 1'b0;
      repeat (4) step();
   endtask

   task automatic send_addr(input logic [6:0] a, input logic rw);
      for (int i = 6; i >= 0; i--) begin
         pos(a[i]);
         neg();
      end
      pos(rw);
   endtask

   task automatic send_wdata(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         neg();
         pos(d[i]);
      end
   endtask

   initial begin
      logic [7:0] rd_val;
      int         exp_we;
      int         exp_pe;
      for (int i = 0; i < 128; i++) mem[i] = 8'(i);
      mem[7'h15] = 8'h96;
      reset = 1'b1; cs_cond = 1'b1; mosi_cond = 1'b0;
      sclk_posedge = 1'b0; sclk_negedge = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();
      check("rst_state",   32'(dut.r_state), 32'(ST_IDLE));
      check("rst_addr",    32'(mem_addr),    32'h0);
      check("rst_wdata",   32'(mem_wdata),   32'h0);
      check("rst_we",      32'(mem_we),      32'h0);
      check("rst_miso",    32'(miso),        32'h0);
      check("rst_miso_en", 32'(miso_en),     32'h0);
      check("rst_perr",    32'(proto_err),   32'h0);

      // Write frame 0x2A <= 0xC3
      cs_cond = 1'b0; step(); step();
      send_addr(7'h2A, 1'b0);
      send_wdata(8'hC3);
      check("wr_we_cnt", 32'(we_cnt),        32'd1);
      check("wr_addr",   32'(we_addr),       32'h2A);
      check("wr_data",   32'(we_data),       32'hC3);
      check("wr_state",  32'(dut.r_state),   32'(ST_DONE));
      send_wdata(8'hFF);
      check("wr_done_no_we", 32'(we_cnt), 32'd1);
      cs_cond = 1'b1; step(); step(); step();
      check("wr_end_idle", 32'(dut.r_state), 32'(ST_IDLE));
      check("wr_no_perr",  32'(pe_cnt),      32'd0);

      // Read frame from 0x15 returning 0x96
      cs_cond = 1'b0; step(); step();
      send_addr(7'h15, 1'b1);
      check("rd_addr",    32'(mem_addr), 32'h15);
      check("rd_miso_en", 32'(miso_en),  32'h1);
      rd_val = 8'h96;
      for (int i = 7; i >= 0; i--) begin
         neg();
         check($sformatf("rd_miso_b%0d", i), 32'(miso), 32'(rd_val[i]));
         pos(1'b0);
      end
      check("rd_miso_en_off", 32'(miso_en),     32'h0);
      check("rd_state",       32'(dut.r_state), 32'(ST_DONE));
      check("rd_no_we",       32'(we_cnt),      32'd1);
      cs_cond = 1'b1; step(); step();

      // Abort after 5 write-data posedges
      exp_pe = pe_cnt;
      cs_cond = 1'b0; step(); step();
      send_addr(7'h10, 1'b0);
      for (int i = 0; i < 5; i++) begin
         neg();
         pos(1'b1);
      end
      cs_cond = 1'b1; step();
      check("ab_state",   32'(dut.r_state), 32'(ST_IDLE));
      check("ab_miso_en", 32'(miso_en),     32'h0);
      repeat (4) step();
      check("ab_no_we",   32'(we_cnt),      32'd1);
      check("ab_perr",    32'(pe_cnt),      32'(exp_pe + PE_PER_ABORT));

      // CS rises together with the 8th write-data posedge
      exp_pe = pe_cnt;
      cs_cond = 1'b0; step(); step();
      send_addr(7'h05, 1'b0);
      for (int i = 0; i < 7; i++) begin
         neg();
         pos(1'b1);
      end
      neg();
      mosi_cond = 1'b1; sclk_posedge = 1'b1; cs_cond = 1'b1;
      step();
      sclk_posedge = 1'b0;
      repeat (4) step();
      check("race_no_we", 32'(we_cnt),      32'd1);
      check("race_state", 32'(dut.r_state), 32'(ST_IDLE));
      check("race_perr",  32'(pe_cnt),      32'(exp_pe + PE_PER_ABORT));

      // Reset after 3 read negedges, then a clean write
      cs_cond = 1'b0; step(); step();
      send_addr(7'h15, 1'b1);
      neg(); pos(1'b0);
      neg(); pos(1'b0);
      neg();
      check("mr_miso_pre", 32'(miso), 32'h0);
      reset = 1'b1; cs_cond = 1'b1;
      step();
      check("mr_miso",    32'(miso),        32'h0);
      check("mr_miso_en", 32'(miso_en),     32'h0);
      check("mr_we",      32'(mem_we),      32'h0);
      check("mr_state",   32'(dut.r_state), 32'(ST_IDLE));
      check("mr_addr",    32'(mem_addr),    32'h0);
      reset = 1'b0; step();
      exp_we = we_cnt + 1;
      cs_cond = 1'b0; step(); step();
      send_addr(7'h7F, 1'b0);
      send_wdata(8'h01);
      check("mr_wr_cnt",  32'(we_cnt),  32'(exp_we));
      check("mr_wr_addr", 32'(we_addr), 32'h7F);
      check("mr_wr_data", 32'(we_data), 32'h01);
      cs_cond = 1'b1; step(); step();

      // Idle noise with CS high
      for (int i = 0; i < 10; i++) begin
         mosi_cond = 1'($urandom_range(1, 0));
         sclk_posedge = 1'b1; step(); sclk_posedge = 1'b0; step();
         sclk_negedge = 1'b1; step(); sclk_negedge = 1'b0; step();
         if (dut.r_state != ST_IDLE) check($sformatf("noise_state_%0d", i), 32'(dut.r_state), 32'(ST_IDLE));
      end
      check("noise_state",   32'(dut.r_state), 32'(ST_IDLE));
      check("noise_addr",    32'(mem_addr),    32'h7F);
      check("noise_wdata",   32'(mem_wdata),   32'h01);
      check("noise_miso",    32'(miso),        32'h0);
      check("noise_miso_en", 32'(miso_en),     32'h0);
      check("noise_we_cnt",  32'(we_cnt),      32'(exp_we));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
